// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon 32/64 round controller.
package simon_pkg;

  typedef enum logic [5:0] {
    StIdle   = 6'b000001,
    StKeyLd  = 6'b000010,
    StKeyGen = 6'b000100,
    StLoad   = 6'b001000,
    StRound  = 6'b010000,
    StDone   = 6'b100000
  } state_e;

  localparam logic CTRL_ENC = 1'b0;
  localparam logic CTRL_DEC = 1'b1;

  function automatic logic [61:0] rev62(input logic [61:0] v);
    logic [61:0] r;
    for (int i = 0; i < 62; i++) begin
      r[i] = v[61-i];
    end
    return r;
  endfunction

  // The literal reads in sequence order; reversing puts the first element at bit 0.
  localparam logic [61:0] SIMON_Z0 =
    rev62(62'b11111010001001010110000111001101111101000100101011000011100110);

  function automatic logic z0_bit(input logic [5:0] idx);
    return (idx < 6'd62) ? SIMON_Z0[idx] : 1'b0;
  endfunction

endpackage

// File: rtl/simon_addr_cnt.sv
// Loadable up/down address counter with an exact-compare terminal flag.
module simon_addr_cnt #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_res_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_up,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_cmp,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_term
);

  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= i_up ? r_cnt + 1'b1 : r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == i_cmp);

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon 32/64 sequencing controller: key load, key expansion, rounds.
// Optional SIMON_KEY_CACHE_EN skips key load/expansion when the cached schedule is valid.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_res_n,
  input  logic              i_start,
  input  logic              i_ctrl,
  input  logic              i_key_new,
  output logic              o_busy,
  output logic              o_key_load,
  output logic              o_key_we,
  output logic              o_z_bit,
  output logic              o_data_load,
  output logic              o_round_en,
  output logic [ADDR_W-1:0] o_key_addr,
  output logic              o_mode,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROUNDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_GEN0 = ADDR_W'(4);

  state_e r_state;
  logic   r_busy, r_key_load, r_key_we, r_z_bit, r_data_load, r_round_en, r_mode, r_done;
`ifdef SIMON_KEY_CACHE_EN
  logic   r_key_valid;
`else
  logic   w_unused_key_new;
  assign w_unused_key_new = i_key_new;
`endif

  logic              w_cnt_load, w_cnt_up, w_cnt_en, w_term;
  logic [ADDR_W-1:0] w_cnt_val, w_cnt_cmp, w_addr;
  logic [5:0]        w_z_idx;

  // z index for the word written next cycle: (key_addr + 1) - 4
  assign w_z_idx = 6'(w_addr) - 6'd3;

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_up   = 1'b1;
    w_cnt_en   = 1'b0;
    w_cnt_cmp  = ADDR_LAST;
    unique case (r_state)
      StIdle:  ;
      StKeyLd: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = ADDR_GEN0;
      end
      StKeyGen: begin
        w_cnt_load = w_term;
        w_cnt_en   = ~w_term;
      end
      StLoad: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = (r_mode == CTRL_DEC) ? ADDR_LAST : '0;
      end
      StRound: begin
        w_cnt_up   = (r_mode == CTRL_ENC);
        w_cnt_cmp  = (r_mode == CTRL_DEC) ? '0 : ADDR_LAST;
        w_cnt_load = w_term;
        w_cnt_en   = ~w_term;
      end
      StDone:  ;
      default: w_cnt_load = 1'b1;
    endcase
  end

  simon_addr_cnt #(
    .ADDR_W(ADDR_W)
  ) u_addr_cnt (
    .i_clk      (i_clk),
    .i_res_n    (i_res_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_up       (w_cnt_up),
    .i_en       (w_cnt_en),
    .i_cmp      (w_cnt_cmp),
    .o_cnt      (w_addr),
    .o_term     (w_term)
  );

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_key_load  <= 1'b0;
      r_key_we    <= 1'b0;
      r_z_bit     <= 1'b0;
      r_data_load <= 1'b0;
      r_round_en  <= 1'b0;
      r_mode      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SIMON_KEY_CACHE_EN
      r_key_valid <= 1'b0;
`endif
    end else begin
      r_key_load  <= 1'b0;
      r_key_we    <= 1'b0;
      r_z_bit     <= 1'b0;
      r_data_load <= 1'b0;
      r_round_en  <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_mode <= i_ctrl;
            r_busy <= 1'b1;
`ifdef SIMON_KEY_CACHE_EN
            if (i_key_new) begin
              r_key_valid <= 1'b0;
            end
            if (r_key_valid && !i_key_new) begin
              r_state     <= StLoad;
              r_data_load <= 1'b1;
            end else begin
              r_state    <= StKeyLd;
              r_key_load <= 1'b1;
            end
`else
            r_state    <= StKeyLd;
            r_key_load <= 1'b1;
`endif
          end
        end
        StKeyLd: begin
          r_state  <= StKeyGen;
          r_key_we <= 1'b1;
          r_z_bit  <= z0_bit(6'd0);
        end
        StKeyGen: begin
          if (w_term) begin
            r_state     <= StLoad;
            r_data_load <= 1'b1;
`ifdef SIMON_KEY_CACHE_EN
            r_key_valid <= 1'b1;
`endif
          end else begin
            r_key_we <= 1'b1;
            r_z_bit  <= z0_bit(w_z_idx);
          end
        end
        StLoad: begin
          r_state    <= StRound;
          r_round_en <= 1'b1;
        end
        StRound: begin
          if (w_term) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end else begin
            r_round_en <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_key_load  = r_key_load;
  assign o_key_we    = r_key_we;
  assign o_z_bit     = r_z_bit;
  assign o_data_load = r_data_load;
  assign o_round_en  = r_round_en;
  assign o_key_addr  = w_addr;
  assign o_mode      = r_mode;
  assign o_done      = r_done;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Self-checking bench for simon_round_ctrl: schedule-based reference model plus directed pins.
module tb_simon_round_ctrl;

  localparam int R = 32;
  localparam int LIMIT = 200;
  localparam string ZSTR = "11111010001001010110000111001101111101000100101011000011100110";

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic start = 1'b0, ctrl = 1'b0, key_new = 1'b0;
  logic busy, key_load, key_we, z_bit, data_load, round_en, mode, done;
  logic [4:0] key_addr;

  logic start5 = 1'b0;
  logic busy5, key_load5, key_we5, z_bit5, data_load5, round_en5, mode5, done5;
  logic [2:0] key_addr5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  simon_round_ctrl #(.ROUNDS(R), .ADDR_W(5)) dut (
    .i_clk(clk), .i_res_n(res_n), .i_start(start), .i_ctrl(ctrl), .i_key_new(key_new),
    .o_busy(busy), .o_key_load(key_load), .o_key_we(key_we), .o_z_bit(z_bit),
    .o_data_load(data_load), .o_round_en(round_en), .o_key_addr(key_addr),
    .o_mode(mode), .o_done(done)
  );

  simon_round_ctrl #(.ROUNDS(5), .ADDR_W(3)) dut5 (
    .i_clk(clk), .i_res_n(res_n), .i_start(start5), .i_ctrl(1'b0), .i_key_new(1'b1),
    .o_busy(busy5), .o_key_load(key_load5), .o_key_we(key_we5), .o_z_bit(z_bit5),
    .o_data_load(data_load5), .o_round_en(round_en5), .o_key_addr(key_addr5),
    .o_mode(mode5), .o_done(done5)
  );

  typedef struct packed {
    logic       busy, key_load, key_we, z, data_load, round_en;
    logic [4:0] addr;
    logic       mode, done;
  } ovec_t;

  logic [13:0] dut_vec;
  assign dut_vec = {busy, key_load, key_we, z_bit, data_load, round_en, key_addr, mode, done};

  // Reference model: on each accepted start, the whole expected output sequence is queued.
  ovec_t q[$];
  bit    q_kv[$];
  ovec_t cur;
  logic  m_mode = 1'b0;
  bit    m_kv = 1'b0;

  function automatic logic zseq(int k);
    return ZSTR[k] == 8'h31;
  endfunction

  function automatic ovec_t idle_vec();
    ovec_t v = '0;
    v.mode = m_mode;
    return v;
  endfunction

  task automatic push(ovec_t v, bit kv);
    q.push_back(v);
    q_kv.push_back(kv);
  endtask

  task automatic build(logic c, logic kn);
    ovec_t v;
    bit skip = 1'b0;
`ifdef SIMON_KEY_CACHE_EN
    if (kn) m_kv = 1'b0;
    skip = m_kv && !kn;
`endif
    m_mode = c;
    if (!skip) begin
      v = '0; v.busy = 1; v.mode = c; v.key_load = 1; push(v, 0);
      for (int a = 4; a < R; a++) begin
        v = '0; v.busy = 1; v.mode = c; v.key_we = 1; v.addr = 5'(a); v.z = zseq(a - 4);
        push(v, 0);
      end
    end
    v = '0; v.busy = 1; v.mode = c; v.data_load = 1; push(v, !skip);
    for (int i = 0; i < R; i++) begin
      v = '0; v.busy = 1; v.mode = c; v.round_en = 1; v.addr = 5'(c ? R - 1 - i : i);
      push(v, 0);
    end
    v = '0; v.busy = 1; v.mode = c; v.done = 1; push(v, 0);
  endtask

  task automatic model_reset();
    q.delete();
    q_kv.delete();
    m_kv = 1'b0;
    m_mode = 1'b0;
    cur = idle_vec();
  endtask

  always @(posedge clk) begin
    if (res_n) begin
      if (!cur.busy && start) build(ctrl, key_new);
      if (q.size() > 0) begin
        cur = q.pop_front();
        if (q_kv.pop_front()) m_kv = 1'b1;
      end else begin
        cur = idle_vec();
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_n) check("cycle_outputs", 64'(dut_vec), 64'(cur));
  end

  task automatic do_start(logic c, logic kn);
    @(negedge clk);
    start = 1'b1; ctrl = c; key_new = kn;
    @(negedge clk);
    start = 1'b0; ctrl = 1'($urandom); key_new = 1'($urandom);
  endtask

  // Returns at the negedge of the done cycle; lat is its cycle number.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic directed_run(logic c, logic kn, int exp_lat, logic full);
    int n = 1;
    int zc = 0;
    logic [5:0] zbits = '0;
    int first_addr = -1;
    do_start(c, kn);
    check("first_cycle_strobes", 64'({key_load, data_load, mode}), 64'({full, ~full, c}));
    while (!done && n < LIMIT) begin
      if (key_we && zc < 6) begin
        zbits = {zbits[4:0], z_bit};
        zc++;
      end
      if (round_en && first_addr < 0) first_addr = int'(key_addr);
      @(negedge clk);
      n++;
    end
    check("done_latency", 64'(n), 64'(exp_lat));
    check("first_round_addr", 64'(first_addr), 64'(c ? 31 : 0));
    if (full) check("z_first6", 64'(zbits), 64'(6'b111110));
  endtask

  initial begin
    int n, lat, dones, we_cnt, we_addr;
    logic c, kn;
    model_reset();
    #2;
    check("reset_outputs", 64'(dut_vec), 64'(0));
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b1;

    // ROUNDS=5 instance: one expansion word at address 4, done in cycle 9.
    @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    n = 1; we_cnt = 0; we_addr = 0;
    while (!done5 && n < LIMIT) begin
      if (key_we5) begin
        we_cnt++;
        we_addr = int'(key_addr5);
      end
      @(negedge clk);
      n++;
    end
    check("r5_latency", 64'(n), 64'(9));
    check("r5_keygen_cycles", 64'(we_cnt), 64'(1));
    check("r5_keygen_addr", 64'(we_addr), 64'(4));

    directed_run(1'b0, 1'b1, 63, 1'b1);
    directed_run(1'b1, 1'b1, 63, 1'b1);
`ifdef SIMON_KEY_CACHE_EN
    directed_run(1'b0, 1'b0, 34, 1'b0);
`else
    directed_run(1'b0, 1'b0, 63, 1'b1);
`endif
    directed_run(1'b0, 1'b1, 63, 1'b1);

    // Starts in cycle 10 and in the done cycle are ignored; the cycle after done accepts.
    do_start(1'b0, 1'b1);
    n = 1; dones = 0;
    while (n < 10) begin
      @(negedge clk); n++;
      if (done) dones++;
    end
    start = 1'b1; ctrl = 1'b1;
    @(negedge clk); n++;
    start = 1'b0;
    while (n < 63) begin
      @(negedge clk); n++;
      if (done) dones++;
    end
    check("done_at_63", 64'(done), 64'(1));
    start = 1'b1; ctrl = 1'b1; key_new = 1'b1;
    @(negedge clk);
    if (done) dones++;
    check("idle_after_done", 64'({busy, done}), 64'(0));
    check("single_done", 64'(dones), 64'(1));
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept", 64'({busy, key_load, mode}), 64'(3'b111));
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'(63));

    // Asynchronous reset in the middle of key expansion.
    do_start(1'b0, 1'b1);
    n = 1;
    while (n < 21) begin
      @(negedge clk); n++;
    end
    check("keygen_before_reset", 64'({key_we, key_addr}), 64'({1'b1, 5'd23}));
    #2;
    res_n = 1'b0;
    model_reset();
    #1;
    check("reset_mid_outputs", 64'(dut_vec), 64'(0));
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b1;
    directed_run(1'b0, 1'b0, 63, 1'b1);

    // Randomized runs with stray starts while busy.
    for (int r = 0; r < 10; r++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
      c = 1'($urandom);
      kn = 1'($urandom);
      do_start(c, kn);
      n = 1;
      while (!done && n < LIMIT) begin
        start = ($urandom_range(0, 7) == 0);
        ctrl = 1'($urandom);
        key_new = 1'($urandom);
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      check("rand_done_seen", 64'(done), 64'(1));
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/simon_round_ctrl.md
# simon_round_ctrl

Sequencing controller for the Simon 32/64 datapath. It accepts an encrypt or decrypt request and drives the datapath through three phases: master-key load, key-schedule expansion into the round-key memory, and the round iterations. Round keys are addressed forward for encryption and in reverse for decryption. It sits between the host-facing command interface and the round/key-expansion datapath, and replaces ad-hoc per-mode state decoding with one counter-driven scheduler.

## Interface
Parameters:
- ROUNDS, 32, number of cipher rounds and round-key words; legal range 5..62.
- ADDR_W, 5, round-key memory address width; requires 2**ADDR_W >= ROUNDS.

Ports:
- clk  input  1  single clock, rising edge.
- res_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- ctrl  input  1  0 = encrypt, 1 = decrypt; captured with start.
- key_new  input  1  master key changed since last run; captured with start.
- busy  output  1  high in every state except IDLE.
- key_load  output  1  one-cycle pulse that writes master-key words 0..3 into key memory.
- key_we  output  1  write strobe for one expanded round key.
- z_bit  output  1  constant-sequence bit for the word being expanded; 0 when key_we is low.
- data_load  output  1  one-cycle pulse that loads the input block into the round registers.
- round_en  output  1  perform one round using the key at key_addr.
- key_addr  output  ADDR_W  key-memory address for writes (KEYGEN) and reads (ROUND).
- mode  output  1  registered copy of ctrl for the datapath.
- done  output  1  one-cycle pulse; the result is valid in the same cycle.

## Operation
- States: IDLE, KEYLD, KEYGEN, LOAD, ROUND, DONE.
- IDLE: start=1 captures ctrl into mode and captures key_new. The next state is KEYLD, or LOAD when the key-cache skip applies (see Configuration). start=0 keeps the block in IDLE.
- KEYLD: key_load=1 for 1 cycle, then KEYGEN.
- KEYGEN: lasts ROUNDS-4 cycles. key_we=1, key_addr counts 4..ROUNDS-1, z_bit = SIMON_Z0[key_addr-4]. Leaves for LOAD when key_addr = ROUNDS-1.
- LOAD: data_load=1 for 1 cycle, then ROUND.
- ROUND: lasts ROUNDS cycles with round_en=1.
  - Encrypt: key_addr counts 0..ROUNDS-1.
  - Decrypt: key_addr counts ROUNDS-1 down to 0.
  - Leaves for DONE on the terminal address.
- DONE: done=1 for 1 cycle, then IDLE.
- key_addr is 0 in IDLE, KEYLD, LOAD and DONE. All strobes are 0 outside their own states.
- start outside IDLE is ignored and not queued. ctrl and key_new are ignored outside the start-accept cycle.
- The counter never wraps. Terminal-count compares are exact against ROUNDS-1 and 0.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, busy=0, key_load=0, key_we=0, z_bit=0, data_load=0, round_en=0, key_addr=0, mode=0, done=0. The key_valid flag (Configuration) is 0.
- Reset asserted mid-operation returns the block to IDLE immediately, with all outputs at their reset values. The partial key schedule is treated as invalid.
- Cycle numbering: start is sampled at rising edge E0; cycle n is the cycle after edge En-1.
- Full path, ROUNDS=32:
  - KEYLD in cycle 1.
  - KEYGEN in cycles 2..29.
  - LOAD in cycle 30.
  - ROUND in cycles 31..62.
  - DONE in cycle 63.
  - Latency = ROUNDS*2 - 1 cycles from start to done.
- Skip path: LOAD in cycle 1, ROUND in cycles 2..ROUNDS+1, DONE in cycle ROUNDS+2.
- busy falls in the cycle after DONE. A start in that same cycle is accepted, giving a back-to-back spacing of one IDLE cycle.

## Configuration
- SIMON_KEY_CACHE_EN defined:
  - A key_valid register is set on leaving KEYGEN.
  - key_valid is cleared by reset, and by accepting a start with key_new=1.
  - A start with key_valid=1 and key_new=0 goes IDLE→LOAD, skipping KEYLD and KEYGEN.
- SIMON_KEY_CACHE_EN undefined: key_valid does not exist, key_new is ignored, and every start goes through KEYLD and KEYGEN.

## Structure
- Package simon_pkg holds:
  - state encoding constants, one-hot, 6 bits;
  - CTRL_ENC=0 and CTRL_DEC=1;
  - SIMON_Z0, 62-bit, stored LSB-first so that bit 0 is the first sequence element. The sequence 11111010001001010110000111001101111101000100101011000011100110 is written left to right into bit 0 upward.
- Sub-module simon_addr_cnt: loadable up/down counter of width ADDR_W.
  - Inputs: load value, up/down select, enable.
  - Output: a terminal flag for the compare value.
  - The FSM instantiates it once, for key_addr.

## Test plan
- Reset, then encrypt, ROUNDS=32:
  - start=1, ctrl=0 → key_load in cycle 1.
  - key_we in cycles 2..29 with key_addr 4..31.
  - z_bit in the first 6 KEYGEN cycles = 1,1,1,1,1,0.
  - data_load in cycle 30; round_en in cycles 31..62 with key_addr 0..31; done in cycle 63.
- Decrypt: ctrl=1 → ROUND phase key_addr runs 31,30,...,0; mode=1; done in cycle 63.
- Cache skip (macro on): encrypt with key_new=1, then start with key_new=0 → LOAD in cycle 1, done in cycle 34. A third start with key_new=1 takes the full 63-cycle path.
- Ignored start: pulse start in cycles 10 and 63 of a run → no effect, and there is exactly one done. A start in the cycle after done is accepted.
- Reset in cycle 20 of KEYGEN: all outputs go to 0 immediately. With the macro on, the next start with key_new=0 still takes the full path.
- ROUNDS=5 build: KEYGEN is 1 cycle at key_addr 4, done in cycle 9.
